// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each accepted Pi strobe becomes HOLD_CYCLES of Lo=1 followed
// by at least GAP_CYCLES of Lo=0, with a one-deep request queue and a drop counter.
module pulse_stretcher #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Pi,
  input  logic       ClrDrop,
  output logic       Lo,
  output logic       Busy,
  output logic       Pend,
  output logic [7:0] DropCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic [7:0] drop_q, drop_d;
  logic       lo_q, lo_d;
  logic       busy_q, busy_d;
  logic       drop_ev;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_ev = 1'b0;

    case (state_q)
      IDLE: begin
        if (Pi) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
        if (Pi) begin
          if (pend_q) drop_ev = 1'b1;
          else        pend_d  = 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == 8'd0) begin
          // Exit edge: a queued request is served first; a simultaneous Pi refills the queue.
          if (pend_q || Pi) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
            pend_d  = pend_q & Pi;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (Pi) begin
            if (pend_q) drop_ev = 1'b1;
            else        pend_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        pend_d  = 1'b0;
      end
    endcase

    if (ClrDrop)
      drop_d = 8'd0;
    else if (drop_ev && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
    else
      drop_d = drop_q;

    lo_d   = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
      drop_q  <= 8'd0;
      lo_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign Lo      = lo_q;
  assign Busy    = busy_q;
  assign Pend    = pend_q;
  assign DropCnt = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random strobes, all checked
// against a timeline model (pulse start edge / end edge) of the stretcher.
module tb_pulse_stretcher;

  localparam int H = 4;
  localparam int G = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Pi = 1'b0;
  logic       ClrDrop = 1'b0;
  logic       Lo, Busy, Pend;
  logic [7:0] DropCnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Model: current pulse started at edge m_s and frees the block at edge m_e.
  int   t = 0;
  bit   m_active = 0;
  int   m_s = 0;
  int   m_e = 0;
  bit   m_pend = 0;
  int   m_drops = 0;

  pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .Clk(Clk), .Reset(Reset), .Pi(Pi), .ClrDrop(ClrDrop),
    .Lo(Lo), .Busy(Busy), .Pend(Pend), .DropCnt(DropCnt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [10:0] exp_vec();
    logic e_lo, e_busy;
    e_lo   = m_active && (t >= m_s) && (t < m_s + H);
    e_busy = m_active && (t < m_e);
    return {e_lo, e_busy, m_pend, 8'(m_drops)};
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_pend   = 0;
    m_drops  = 0;
  endtask

  task automatic tick(input logic p, input logic c);
    bit dropped;
    @(negedge Clk);
    Pi = p;
    ClrDrop = c;
    @(posedge Clk);
    t++;
    dropped = 0;
    if (m_active && t < m_e) begin
      if (p) begin
        if (m_pend) dropped = 1;
        else        m_pend  = 1;
      end
    end else if (m_pend || p) begin
      m_active = 1;
      m_s      = t;
      m_e      = t + H + G;
      m_pend   = m_pend & p;
    end else begin
      m_active = 0;
    end
    if (c)                           m_drops = 0;
    else if (dropped && m_drops < 255) m_drops++;
    #1;
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++;
    if ({Lo, Busy, Pend, DropCnt} !== 11'd0)
      $display("FAIL reset_immediate got=%h want=%h", {Lo, Busy, Pend, DropCnt}, 11'd0);
    else pass_cnt++;
    Pi = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk_cnt++;
    if ({Lo, Busy, Pend, DropCnt} !== 11'd0)
      $display("FAIL reset_ignores_pi got=%h want=%h", {Lo, Busy, Pend, DropCnt}, 11'd0);
    else pass_cnt++;
    @(negedge Clk);
    Pi = 1'b0;
    Reset = 1'b0;
    model_reset();
    $display("reset: checked idle outputs while Reset held");
  endtask

  task automatic test_single_pulse();
    int lo_n = 0, busy_n = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      lo_n += Lo;
      busy_n += Busy;
      chk_cnt++;
      if ({Lo, Busy, Pend, DropCnt} !== exp_vec())
        $display("FAIL single_cycle%0d got=%h want=%h", i, {Lo, Busy, Pend, DropCnt}, exp_vec());
      else pass_cnt++;
      tick(1'b0, 1'b0);
    end
    chk_cnt++;
    if (lo_n !== H || busy_n !== H + G)
      $display("FAIL single_lengths got lo=%0d busy=%0d want lo=%0d busy=%0d", lo_n, busy_n, H, H + G);
    else pass_cnt++;
    $display("single_pulse: lo=%0d busy=%0d", lo_n, busy_n);
  endtask

  task automatic test_queued();
    logic saw_idle = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk_cnt++;
    if (Pend !== 1'b1) $display("FAIL queued_pend got=%b want=1", Pend);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      if (i < 6 && !Busy) saw_idle = 1;
      chk_cnt++;
      if ({Lo, Busy, Pend, DropCnt} !== exp_vec())
        $display("FAIL queued_cycle%0d got=%h want=%h", i, {Lo, Busy, Pend, DropCnt}, exp_vec());
      else pass_cnt++;
      tick(1'b0, 1'b0);
    end
    chk_cnt++;
    if (saw_idle || Pend !== 1'b0 || DropCnt !== 8'd0)
      $display("FAIL queued_end got idle_gap=%b pend=%b drop=%0d want 0/0/0", saw_idle, Pend, DropCnt);
    else pass_cnt++;
    $display("queued: back-to-back pulses pend=%b drop=%0d", Pend, DropCnt);
  endtask

  task automatic test_overflow();
    int lo_n = 0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk_cnt++;
    if (Pend !== 1'b1 || DropCnt !== 8'd1)
      $display("FAIL overflow_three got pend=%b drop=%0d want pend=1 drop=1", Pend, DropCnt);
    else pass_cnt++;
    for (int i = 0; i < 330; i++) begin
      tick(1'b1, 1'b0);
      if (i >= 270) lo_n += Lo;
      chk_cnt++;
      if ({Lo, Busy, Pend, DropCnt} !== exp_vec())
        $display("FAIL overflow_cycle%0d got=%h want=%h", i, {Lo, Busy, Pend, DropCnt}, exp_vec());
      else pass_cnt++;
    end
    chk_cnt++;
    if (DropCnt !== 8'd255 || lo_n !== 40)
      $display("FAIL overflow_saturate got drop=%0d lo60=%0d want drop=255 lo60=40", DropCnt, lo_n);
    else pass_cnt++;
    $display("overflow: drop=%0d lo_in_60=%0d", DropCnt, lo_n);
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk_cnt++;
    if ({Lo, Busy, Pend, DropCnt} !== 11'd0)
      $display("FAIL async_reset got=%h want=%h", {Lo, Busy, Pend, DropCnt}, 11'd0);
    else pass_cnt++;
    Reset = 1'b0;
    model_reset();
    tick(1'b1, 1'b0);
    chk_cnt++;
    if ({Lo, Busy, Pend, DropCnt} !== exp_vec() || Lo !== 1'b1)
      $display("FAIL post_reset_start got=%h want=%h", {Lo, Busy, Pend, DropCnt}, exp_vec());
    else pass_cnt++;
    repeat (8) tick(1'b0, 1'b0);
    $display("async_reset: outputs cleared between edges");
  endtask

  task automatic test_gap_collision();
    logic [7:0] drop_before;
    logic       pat [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drop_before = DropCnt;
    for (int i = 0; i < 7; i++) tick(pat[i], 1'b0);
    chk_cnt++;
    if (Lo !== 1'b1 || Pend !== 1'b1 || DropCnt !== drop_before)
      $display("FAIL gap_collision got lo=%b pend=%b drop=%0d want lo=1 pend=1 drop=%0d",
               Lo, Pend, DropCnt, drop_before);
    else pass_cnt++;
    chk_cnt++;
    if ({Lo, Busy, Pend, DropCnt} !== exp_vec())
      $display("FAIL gap_collision_model got=%h want=%h", {Lo, Busy, Pend, DropCnt}, exp_vec());
    else pass_cnt++;
    repeat (14) tick(1'b0, 1'b0);
    $display("gap_collision: pend=%b drop=%0d", Pend, DropCnt);
  endtask

  task automatic test_clear_priority();
    int guard = 0;
    while (m_drops != 5 && guard < 50) begin
      tick(1'b1, 1'b0);
      guard++;
    end
    chk_cnt++;
    if (DropCnt !== 8'd5)
      $display("FAIL clear_setup got drop=%0d want 5", DropCnt);
    else pass_cnt++;
    chk_cnt++;
    if (!(Busy && Pend && m_active && t < m_e - 1))
      $display("FAIL clear_setup_state got busy=%b pend=%b want a drop-ready state", Busy, Pend);
    else pass_cnt++;
    tick(1'b1, 1'b1);
    chk_cnt++;
    if (DropCnt !== 8'd0)
      $display("FAIL clear_priority got drop=%0d want 0", DropCnt);
    else pass_cnt++;
    repeat (14) tick(1'b0, 1'b0);
    $display("clear_priority: drop=%0d", DropCnt);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 2000; i++) begin
      int unsigned dens;
      dens = (i / 250) % 4;
      tick(($urandom_range(0, 7) < 2 * dens + 1), ($urandom_range(0, 63) == 0));
      chk_cnt++;
      if ({Lo, Busy, Pend, DropCnt} !== exp_vec()) begin
        errs++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, {Lo, Busy, Pend, DropCnt}, exp_vec());
      end else pass_cnt++;
    end
    $display("random: 2000 cycles errors=%0d", errs);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_queued();
    test_overflow();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    model_reset();
    test_async_reset();
    test_gap_collision();
    test_clear_priority();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
